// File: rtl/booth_mult_if.sv
// Operand/product handshake bundle for booth_mult_seq.
// The master side presents operands and accepts the product; the slave side is the multiplier.
interface booth_mult_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;

  modport master (
    output in_valid, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential signed radix-2 Booth multiplier, one step per cycle through a WIDTH-bit add/sub stage.
// Optional ZERO_SKIP_EN: a zero operand bypasses RUN and retires a zero product immediately.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// RUN    | one Booth add/sub + arithmetic shift per cycle
// DONE   | product valid, held until out_ready
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  booth_mult_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  // add/sub stage signals
  logic                 do_op;
  logic                 sub;
  logic [WIDTH-1:0]     opb;
  logic [WIDTH-1:0]     sum;
  logic                 ovf;
  logic [WIDTH-1:0]     a_res;
  logic                 sign_true;

  always_comb begin
    do_op = q_q[0] ^ q1_q;
    sub   = q_q[0] & ~q1_q;
    opb   = m_q ^ {WIDTH{sub}};
    sum   = a_q + opb + {{(WIDTH-1){1'b0}}, sub};
    ovf   = (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    // The shift must carry the sign of the unwrapped result, not of the wrapped sum.
    a_res     = do_op ? sum : a_q;
    sign_true = do_op ? (sum[WIDTH-1] ^ ovf) : a_q[WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = S_RUN;
`ifdef ZERO_SKIP_EN
          if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
            prod_d  = '0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RUN: begin
        a_d   = {sign_true, a_res[WIDTH-1:1]};
        q_d   = {a_res[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          prod_d  = {sign_true, a_res[WIDTH-1:1], a_res[0], q_q[WIDTH-1:1]};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.product   = prod_q;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq against a signed-multiply scoreboard.
// Latency is counted as cycles from the accept edge up to the first cycle showing out_valid.
module tb_booth_mult_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_if #(.WIDTH(W)) bus ();
  booth_mult_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [2*W-1:0] sb[$];

`ifdef ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W + 1;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [W-1:0]   ms;
    logic signed [W-1:0]   qs;
    logic signed [2*W-1:0] p;
    ms = m;
    qs = q;
    p  = ms * qs;
    return p;
  endfunction

  // Presents an operand pair, waits for acceptance and records the expected product.
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid     = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    tick();
    bus.in_valid = 1'b0;
    sb.push_back(model(m, q));
  endtask

  // Waits for out_valid, checks latency/product, then retires it with out_ready.
  task automatic collect(input string tag, input int exp_lat, input bit chk_lat);
    int n;
    logic [2*W-1:0] exp;
    n = 1;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    if (chk_lat) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_prod"}, 32'(bus.product), 32'(exp));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (chk_lat) chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [2*W-1:0] held;
    logic [W-1:0]   rm, rq;
    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.out_ready    = 1'b0;

    // 1. reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_product",   32'(bus.product),   32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // 2. basic product and latency
    issue(8'd3, 8'd5);
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_in_ready", 32'(bus.in_ready), 32'd0);
    chk("exp_3x5", 32'(sb[0]), 32'h000F);
    collect("m3q5", W + 1, 1'b1);

    // 3. signed and boundary operands
    issue(8'hF9, 8'd6);
    collect("m-7q6", W + 1, 1'b1);
    issue(8'h80, 8'h80);
    collect("m-128q-128", W + 1, 1'b1);
    issue(8'h7F, 8'h80);
    collect("m127q-128", W + 1, 1'b1);
    issue(8'h80, 8'h01);
    collect("m-128q1", W + 1, 1'b1);
    issue(8'h80, 8'h7F);
    collect("m-128q127", W + 1, 1'b1);

    // 4. backpressure in DONE; in_valid pulses must be ignored
    issue(8'd11, 8'hF3);
    while (!bus.out_valid) tick();
    held = bus.product;
    chk("bp_prod_entry", 32'(held), 32'(sb[0]));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid     = 1'b1;
      bus.multiplicand = 8'(i + 40);
      bus.multiplier   = 8'd9;
      tick();
      bus.in_valid = 1'b0;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_product",   32'(bus.product),   32'(held));
    end
    collect("bp", 0, 1'b0);
    chk("bp_idle_after", 32'(bus.in_ready), 32'd1);
    chk("bp_not_busy",   32'(bus.busy),     32'd0);

    // 5. reset during the 4th RUN cycle aborts the operation
    issue(8'd10, 8'd10);
    tick();
    tick();
    tick();
    chk("abort_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_product",   32'(bus.product),   32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_busy_low",  32'(bus.busy),      32'd0);
    issue(8'd2, 8'hFD);
    chk("exp_2x-3", 32'(sb[0]), 32'hFFFA);
    collect("m2q-3", W + 1, 1'b1);

    // 6. zero operands
    issue(8'd0, 8'd55);
    collect("m0q55", ZERO_LAT, 1'b1);
    issue(8'd77, 8'd0);
    collect("m77q0", ZERO_LAT, 1'b1);

    // random signed sweep
    for (int i = 0; i < 1000; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      issue(rm, rq);
      collect("rand", 0, 1'b0);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
